// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between NREQ writeback
//   sources using round-robin arbitration. It also keeps a pending-write
//   scoreboard that decode uses to find registers whose producer has not
//   yet written back. Register ZERO_REG is never written and never marked
//   pending.
//
// Ports
//   Clk       clock; all state changes on the rising edge
//   Reset_n   asynchronous reset, active low
//   ReqValid  per-lane write request
//   ReqAddr   per-lane destination register, lane i = [5i+4:5i]
//   ReqData   per-lane write data, lane i = [DW*i+DW-1:DW*i]
//   ReqReady  one-hot grant; a transfer happens when Valid & Ready
//   RsvValid  decode wants to reserve RsvAddr
//   RsvAddr   register being reserved
//   RsvReady  reservation accepted this cycle
//   Flush     drop every outstanding reservation
//   Pending   bit r set: register r reserved, write not yet issued
//   RegWr     register-file write enable (registered)
//   RW        register-file write address (registered)
//   BusW      register-file write data (registered)
module regfile_wb_arbiter #(
  parameter int NREQ     = 3,
  parameter int DW       = 64,
  parameter int ZERO_REG = 31
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NREQ-1:0]    ReqValid,
  input  logic [5*NREQ-1:0]  ReqAddr,
  input  logic [DW*NREQ-1:0] ReqData,
  output logic [NREQ-1:0]    ReqReady,
  input  logic               RsvValid,
  input  logic [4:0]         RsvAddr,
  output logic               RsvReady,
  input  logic               Flush,
  output logic [31:0]        Pending,
  output logic               RegWr,
  output logic [4:0]         RW,
  output logic [DW-1:0]      BusW
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0] ZR = 5'(ZERO_REG);
  localparam logic [PW-1:0] LAST_LANE = PW'(NREQ - 1);

  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [31:0]     pending_reg, pending_next;
  logic            reg_wr_reg;
  logic [4:0]      rw_reg;
  logic [DW-1:0]   bus_w_reg;

  logic [4:0]      lane_addr [NREQ];
  logic [DW-1:0]   lane_data [NREQ];

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic            xfer;
  logic [4:0]      sel_addr;
  logic [DW-1:0]   sel_data;
  logic            do_write;
  logic            rsv_ok;

  // Unpack the flat request buses into per-lane views.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_addr[gi] = ReqAddr[5*gi +: 5];
      assign lane_data[gi] = ReqData[DW*gi +: DW];
    end
  endgenerate

  // Round-robin scan starting at the pointer, wrapping modulo NREQ.
  always_comb begin : arb_comb
    int idx;
    logic [PW-1:0] idx_l;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_l       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_l = PW'(idx);
      if (!grant_found && ReqValid[idx_l]) begin
        grant_found  = 1'b1;
        grant[idx_l] = 1'b1;
        grant_idx    = idx_l;
      end
    end
  end

  // Grants are suppressed while reset is held so no transfer can be seen.
  assign ReqReady = Reset_n ? grant : '0;
  assign xfer     = Reset_n & grant_found;
  assign sel_addr = lane_addr[grant_idx];
  assign sel_data = lane_data[grant_idx];
  // A transfer to the zero register is consumed but never reaches the file.
  assign do_write = xfer && (sel_addr != ZR);

  assign rsv_ok   = !Flush && ((RsvAddr == ZR) || !pending_reg[RsvAddr]);
  assign RsvReady = Reset_n & rsv_ok;

  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      ptr_next = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
    end
  end

  // Clear from writeback is applied before set from reservation, so a
  // same-cycle retire and re-reserve of one register leaves it pending.
  always_comb begin
    pending_next = pending_reg;
    if (Flush) begin
      pending_next = '0;
    end else begin
      if (do_write) begin
        pending_next[sel_addr] = 1'b0;
      end
      if (RsvValid && RsvReady && (RsvAddr != ZR)) begin
        pending_next[RsvAddr] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_reg     <= '0;
      pending_reg <= '0;
      reg_wr_reg  <= 1'b0;
      rw_reg      <= '0;
      bus_w_reg   <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      pending_reg <= pending_next;
      reg_wr_reg  <= do_write;
      // Address/data hold their last values when nothing is written.
      if (do_write) begin
        rw_reg    <= sel_addr;
        bus_w_reg <= sel_data;
      end
    end
  end

  assign Pending = pending_reg;
  assign RegWr   = reg_wr_reg;
  assign RW      = rw_reg;
  assign BusW    = bus_w_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Self-checking bench: a reference model of the arbiter and scoreboard
//   predicts grants and pending bits each cycle; predicted register-file
//   writes are queued and compared when the DUT presents them.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;

  logic               Clk;
  logic               Reset_n;
  logic [NREQ-1:0]    ReqValid;
  logic [5*NREQ-1:0]  ReqAddr;
  logic [DW*NREQ-1:0] ReqData;
  logic [NREQ-1:0]    ReqReady;
  logic               RsvValid;
  logic [4:0]         RsvAddr;
  logic               RsvReady;
  logic               Flush;
  logic [31:0]        Pending;
  logic               RegWr;
  logic [4:0]         RW;
  logic [DW-1:0]      BusW;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .ZERO_REG(31)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady),
    .RsvValid(RsvValid), .RsvAddr(RsvAddr), .RsvReady(RsvReady),
    .Flush(Flush), .Pending(Pending),
    .RegWr(RegWr), .RW(RW), .BusW(BusW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t         wq[$];
  int          checks = 0;
  int          errors = 0;
  int          mptr   = 0;
  logic [31:0] mpend  = '0;
  logic [63:0] rf [32];

  // Register file model: samples the write port on the falling edge.
  always @(negedge Clk) begin
    if (RegWr) rf[RW] <= BusW;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    ReqValid[i]      = v;
    ReqAddr[5*i +: 5] = a;
    ReqData[64*i +: 64] = d;
  endtask

  // One clock cycle: check combinational outputs mid-cycle against the
  // model, queue the expected write, then compare registered outputs.
  task automatic step(input string tag);
    int          g;
    int          idx;
    logic [2:0]  eg;
    logic        exp_rsv;
    logic [4:0]  a;
    logic [63:0] d;
    wr_t         e;
    #3;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (g < 0 && ReqValid[idx]) g = idx;
    end
    eg = (g >= 0) ? (3'b001 << g) : 3'b000;
    exp_rsv = !Flush && (RsvAddr == 5'd31 || !mpend[RsvAddr]);
    check({tag, ".grant"}, 64'(ReqReady), 64'(eg));
    check({tag, ".rsv_ready"}, 64'(RsvReady), 64'(exp_rsv));
    a = 5'd0;
    d = 64'd0;
    if (g >= 0) begin
      a = ReqAddr[5*g +: 5];
      d = ReqData[64*g +: 64];
      mptr = (g + 1) % NREQ;
    end
    wq.push_back('{wr: (g >= 0) && (a != 5'd31), a: a, d: d});
    if (Flush) begin
      mpend = '0;
    end else begin
      if (g >= 0 && a != 5'd31) mpend[a] = 1'b0;
      if (RsvValid && exp_rsv && RsvAddr != 5'd31) mpend[RsvAddr] = 1'b1;
    end
    @(posedge Clk);
    #1;
    if (wq.size() == 0) begin
      check({tag, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = wq.pop_front();
      check({tag, ".reg_wr"}, 64'(RegWr), 64'(e.wr));
      if (e.wr) begin
        check({tag, ".rw"}, 64'(RW), 64'(e.a));
        check({tag, ".bus_w"}, BusW, e.d);
      end
    end
    check({tag, ".pending"}, 64'(Pending), 64'(mpend));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    Reset_n  = 1'b0;
    ReqValid = '1;
    ReqAddr  = '0;
    ReqData  = '0;
    RsvValid = 1'b1;
    RsvAddr  = 5'd3;
    Flush    = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    // Reset state: outputs cleared, handshakes suppressed.
    check("rst.reg_wr", 64'(RegWr), 64'd0);
    check("rst.rw", 64'(RW), 64'd0);
    check("rst.bus_w", BusW, 64'd0);
    check("rst.pending", 64'(Pending), 64'd0);
    check("rst.req_ready", 64'(ReqReady), 64'd0);
    check("rst.rsv_ready", 64'(RsvReady), 64'd0);
    ReqValid = '0;
    RsvValid = 1'b0;
    Reset_n  = 1'b1;

    // All three lanes valid: round-robin 0,1,2,0,1,2.
    set_lane(0, 1'b1, 5'd1, 64'h1111_0000_0000_0001);
    set_lane(1, 1'b1, 5'd2, 64'h2222_0000_0000_0002);
    set_lane(2, 1'b1, 5'd3, 64'h3333_0000_0000_0003);
    for (int i = 0; i < 6; i++) step("rr");
    ReqValid = '0;
    step("idle");
    check("rf.x1", rf[1], 64'h1111_0000_0000_0001);
    check("rf.x3", rf[3], 64'h3333_0000_0000_0003);

    // Zero-register write: granted, consumed, never reaches the file.
    set_lane(1, 1'b1, 5'd31, 64'hDEAD);
    step("zero");
    ReqValid = '0;
    step("idle");
    check("rf.x31", rf[31], 64'd0);
    // Pointer should now be 2: lane2 wins over lane0.
    set_lane(0, 1'b1, 5'd8, 64'hA0);
    set_lane(2, 1'b1, 5'd9, 64'hA2);
    step("ptr2");
    ReqValid = '0;

    // Lane2 alone with pointer 0, then lane0 beats lane2.
    set_lane(2, 1'b1, 5'd10, 64'hB2);
    step("lane2");
    set_lane(0, 1'b1, 5'd11, 64'hC0);
    set_lane(2, 1'b1, 5'd12, 64'hC2);
    step("lane0");
    ReqValid = '0;
    step("idle");

    // Reservations on X5, stall, retire, retire+re-reserve same cycle.
    RsvValid = 1'b1; RsvAddr = 5'd5;
    step("rsv5");
    step("rsv5.stall");
    RsvValid = 1'b0;
    set_lane(0, 1'b1, 5'd5, 64'h55);
    step("wb5");
    RsvValid = 1'b1;
    set_lane(0, 1'b1, 5'd5, 64'h56);
    step("wb5.rsv5");
    check("pend5", 64'(Pending[5]), 64'd1);
    ReqValid = '0;
    RsvAddr = 5'd31;
    step("rsv31");

    // Build Pending = 0xF0, then flush with a reservation request.
    RsvAddr = 5'd4; step("rsv4");
    RsvAddr = 5'd6; step("rsv6");
    RsvAddr = 5'd7; step("rsv7");
    check("pend.f0", 64'(Pending), 64'h0000_00F0);
    Flush = 1'b1; RsvAddr = 5'd9;
    step("flush");
    Flush = 1'b0; RsvValid = 1'b0;
    check("pend.flushed", 64'(Pending), 64'd0);

    // Reset asserted while a write is on the port.
    RsvValid = 1'b1; RsvAddr = 5'd12;
    set_lane(0, 1'b1, 5'd7, 64'h77);
    step("prerst");
    RsvValid = 1'b0;
    check("prerst.reg_wr", 64'(RegWr), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst.reg_wr", 64'(RegWr), 64'd0);
    check("midrst.rw", 64'(RW), 64'd0);
    check("midrst.bus_w", BusW, 64'd0);
    check("midrst.pending", 64'(Pending), 64'd0);
    check("midrst.req_ready", 64'(ReqReady), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
